mac_array_ctrl: RTL and testbench
=================================

Name: mac_array_ctrl

Overview:
Multi-lane integer MAC engine. It is the parametrised successor of the single-lane non-pipelined MAC top.
- LANES independent multiply-accumulate lanes, each taking IN_W-bit operands.
- Accumulates over a programmable vector length, then presents ACC_W-bit results through a valid/ready output handshake.
- Supports signed/unsigned arithmetic, optional saturation and per-lane sticky overflow.
- Sits between the operand fetch stage (input handshake) and the result writeback (output handshake).

Parameters:
LANES, 4, number of parallel MAC lanes
IN_W, 8, operand width per lane
ACC_W, 24, accumulator/result width per lane (must be >= 2*IN_W)
LEN_W, 8, width of vector-length config field

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous reset, active low
cfg_we  input  1  config write strobe
cfg_signed  input  1  1: two's-complement operands, 0: unsigned
cfg_sat  input  1  1: saturate on overflow, 0: wrap
cfg_len  input  LEN_W  vector length minus one (L = cfg_len+1 beats)
in_valid  input  1  operand beat valid
in_ready  output  1  engine accepts a beat
in_a  input  LANES*IN_W  lane i operand A at bits [i*IN_W +: IN_W]
in_b  input  LANES*IN_W  lane i operand B, same packing
out_valid  output  1  result vector valid
out_ready  input  1  downstream accepts result
out_acc  output  LANES*ACC_W  lane i result at [i*ACC_W +: ACC_W]
out_ovf  output  LANES  per-lane overflow flag for the presented vector
busy  output  1  state != IDLE
error  output  1  sticky illegal-config flag

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1, out_valid=0, out_acc=0, out_ovf=0, busy=0, error=0.
  - Beat counter=0, accumulators=0.
  - Config defaults: signed=1, sat=0, len=0.
- Reset mid-vector discards the partial vector; no output is produced.
- States:
  - IDLE: no beat of the current vector accepted yet.
  - ACC: 1..L-1 beats accepted.
  - HOLD: result presented.
- Config:
  - cfg_we in IDLE latches cfg_signed/cfg_sat/cfg_len and clears error.
  - cfg_we in ACC or HOLD is ignored and sets error=1 (sticky).
  - If cfg_we and an input beat occur in the same IDLE cycle, the config is applied first, so the beat uses the new config.
- Beat accept: in_valid & in_ready. in_ready = (state != HOLD).
- Per-lane arithmetic on an accepted beat:
  - p = a*b at 2*IN_W bits, signed or unsigned per cfg_signed.
  - p is extended to ACC_W+1 bits; sum = (first beat ? p : acc + p).
  - The first beat of a vector loads the product; no stale accumulation.
  - If sum exceeds the ACC_W range (signed: [-2^(ACC_W-1), 2^(ACC_W-1)-1]; unsigned: [0, 2^ACC_W-1]):
    - the lane's ovf bit is set (sticky for the vector);
    - with cfg_sat=1, acc takes the range limit in the overflow direction;
    - with cfg_sat=0, acc takes the low ACC_W bits.
- Counter and transitions:
  - The beat counter increments per accepted beat.
  - IDLE -> ACC on the first beat when L>1.
  - IDLE/ACC -> HOLD on the L-th beat; L=1 goes IDLE -> HOLD directly.
- Latency: out_valid rises the cycle after the L-th beat is accepted. out_acc/out_ovf are registered and carry the final values.
- HOLD:
  - out_valid=1; out_acc and out_ovf stay stable until handshake; in_ready=0.
  - out_valid & out_ready -> IDLE next cycle with counter cleared and ovf cleared; out_valid=0.
- in_valid while in HOLD is not accepted (no data loss: the source holds).
- Throughput: L+1 cycles per vector minimum (one HOLD cycle).
- out_acc retains its last value after handshake (not zeroed); out_valid is the only qualifier.

Test Plan:
1. Signed, len=2 (3 beats), lane0 a=3 b=4 and lane1 a=-2 b=5 on every beat, out_ready=1 -> one cycle after beat 3: out_valid=1, lane0=36, lane1=-30 (0xFFFFE2), out_ovf=0; IDLE next cycle.
2. Backpressure: same vector with out_ready=0 for 5 cycles -> in_ready=0 and out_acc constant throughout; after handshake, a new 1-beat vector with a=1 b=1 gives 1 (no residue from 36).
3. ACC_W=16, signed, len=1, lane0 a=-128 b=-128 twice -> sum 32768: with sat=1 result 32767 (0x7FFF) and ovf[0]=1; with sat=0 result 0x8000 and ovf[0]=1; other lanes ovf=0.
4. Unsigned, len=0, lane2 a=255 b=255 -> single-beat vector; result 65025 (0x00FE01) at lane2 after 1 cycle, ovf=0; signed mode with the same bits gives 1.
5. cfg_we with len=5 during ACC -> ignored (vector still completes at the original L), error=1; a later cfg_we in IDLE -> error=0 and the new L=6 takes effect.
6. rst_n pulsed low mid-vector (after beat 2 of 4) -> outputs immediately return to reset values; the next 1-beat vector (defaults, signed) with a=7 b=-3 gives -21.

Source files
------------

// File: rtl/mac_array_ctrl.sv
// mac_array_ctrl: multi-lane integer multiply-accumulate engine.
// Accepts LANES operand pairs per beat over a programmable vector length and
// presents per-lane results through a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   cfg_we/cfg_signed/cfg_sat/cfg_len   config write (honoured only in IDLE)
//   in_valid/in_ready/in_a/in_b         operand beat handshake, lane-packed
//   out_valid/out_ready/out_acc/out_ovf result handshake, lane-packed
//   busy                       engine is mid-vector or holding a result
//   error                      sticky flag: config written while not IDLE
module mac_array_ctrl #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = 8,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned LEN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic                   cfg_signed,
  input  logic                   cfg_sat,
  input  logic [LEN_W-1:0]       cfg_len,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*IN_W-1:0]  in_a,
  input  logic [LANES*IN_W-1:0]  in_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*ACC_W-1:0] out_acc,
  output logic [LANES-1:0]       out_ovf,
  output logic                   busy,
  output logic                   error
);

  localparam int unsigned PW = 2 * IN_W;
  localparam int unsigned XW = ACC_W + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

  logic [1:0]             state_q, state_d;
  logic                   cfg_signed_q, cfg_sat_q;
  logic [LEN_W-1:0]       cfg_len_q, cnt_q;
  logic [LANES*ACC_W-1:0] acc_q, acc_d;
  logic [LANES-1:0]       ovf_q, ovf_d;

  logic                   cfg_apply, eff_signed, eff_sat;
  logic [LEN_W-1:0]       eff_len;
  logic                   beat, last_beat, hs, first_beat;

  // A config write in IDLE takes effect for a beat arriving in the same cycle.
  assign cfg_apply  = cfg_we && (state_q == IDLE);
  assign eff_signed = cfg_apply ? cfg_signed : cfg_signed_q;
  assign eff_sat    = cfg_apply ? cfg_sat    : cfg_sat_q;
  assign eff_len    = cfg_apply ? cfg_len    : cfg_len_q;

  assign beat       = in_valid && in_ready;
  assign last_beat  = beat && (cnt_q == eff_len);
  assign hs         = out_valid && out_ready;
  assign first_beat = (state_q == IDLE);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (beat) state_d = last_beat ? HOLD : ACC;
      ACC:     if (last_beat) state_d = HOLD;
      HOLD:    if (hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Per-lane multiply, extend to ACC_W+1, accumulate, range-check and clamp/wrap
  always_comb begin
    logic [IN_W-1:0]  a_op, b_op;
    logic [PW-1:0]    a_x, b_x, prod;
    logic [ACC_W-1:0] acc_l, res;
    logic [XW-1:0]    p_ext, a_ext, sum;
    logic             lane_ovf;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    a_op     = '0;
    b_op     = '0;
    a_x      = '0;
    b_x      = '0;
    prod     = '0;
    acc_l    = '0;
    res      = '0;
    p_ext    = '0;
    a_ext    = '0;
    sum      = '0;
    lane_ovf = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      a_op  = in_a[i*IN_W +: IN_W];
      b_op  = in_b[i*IN_W +: IN_W];
      // Low PW bits of the product of extended operands equal the exact product.
      a_x   = {{IN_W{eff_signed & a_op[IN_W-1]}}, a_op};
      b_x   = {{IN_W{eff_signed & b_op[IN_W-1]}}, b_op};
      prod  = a_x * b_x;
      acc_l = acc_q[i*ACC_W +: ACC_W];
      p_ext = {{(XW-PW){eff_signed & prod[PW-1]}}, prod};
      a_ext = {eff_signed & acc_l[ACC_W-1], acc_l};
      sum   = first_beat ? p_ext : (a_ext + p_ext);
      lane_ovf = eff_signed ? (sum[XW-1] ^ sum[XW-2]) : sum[XW-1];
      if (lane_ovf && eff_sat) begin
        if (eff_signed) res = sum[XW-1] ? SMIN : SMAX;
        else            res = UMAX;
      end else begin
        res = sum[ACC_W-1:0];
      end
      if (beat) begin
        acc_d[i*ACC_W +: ACC_W] = res;
        ovf_d[i] = (first_beat ? 1'b0 : ovf_q[i]) | lane_ovf;
      end
    end
  end

  // State, config, counter and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cfg_signed_q <= 1'b1;
      cfg_sat_q    <= 1'b0;
      cfg_len_q    <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      ovf_q        <= '0;
      error        <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      out_acc      <= '0;
      out_ovf      <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      in_ready  <= (state_d != HOLD);
      out_valid <= (state_d == HOLD);
      busy      <= (state_d != IDLE);
      if (cfg_apply) begin
        cfg_signed_q <= cfg_signed;
        cfg_sat_q    <= cfg_sat;
        cfg_len_q    <= cfg_len;
      end
      if (cfg_we) error <= (state_q != IDLE);
      if (hs || last_beat) cnt_q <= '0;
      else if (beat)       cnt_q <= cnt_q + LEN_W'(1);
      if (last_beat) begin
        out_acc <= acc_d;
        out_ovf <= ovf_d;
      end else if (hs) begin
        out_ovf <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Self-checking bench for mac_array_ctrl: drives two instances (ACC_W=24 and
// ACC_W=16) with identical stimulus and compares both against an arithmetic
// reference model of the vector dot-product rules.
module tb_mac_array_ctrl;

  localparam int unsigned LANES = 4;
  localparam int unsigned IN_W  = 8;
  localparam int unsigned LEN_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0, cfg_signed = 1'b0, cfg_sat = 1'b0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [LANES*IN_W-1:0] in_a = '0, in_b = '0;

  logic in_ready24, out_valid24, busy24, error24;
  logic in_ready16, out_valid16, busy16, error16;
  logic [LANES*24-1:0] out_acc24;
  logic [LANES*16-1:0] out_acc16;
  logic [LANES-1:0] out_ovf24, out_ovf16;

  int total = 0;
  int bad = 0;
  bit cur_sgn = 1'b1, cur_sat = 1'b0;
  logic [LANES*IN_W-1:0] va [16];
  logic [LANES*IN_W-1:0] vb [16];

  always #5 clk = ~clk;

  mac_array_ctrl #(.LANES(LANES), .IN_W(IN_W), .ACC_W(24), .LEN_W(LEN_W)) u_dut24 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_signed(cfg_signed), .cfg_sat(cfg_sat),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready24), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid24), .out_ready(out_ready), .out_acc(out_acc24), .out_ovf(out_ovf24),
    .busy(busy24), .error(error24));

  mac_array_ctrl #(.LANES(LANES), .IN_W(IN_W), .ACC_W(16), .LEN_W(LEN_W)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_signed(cfg_signed), .cfg_sat(cfg_sat),
    .cfg_len(cfg_len), .in_valid(in_valid), .in_ready(in_ready16), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16), .out_ovf(out_ovf16),
    .busy(busy16), .error(error16));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference: exact dot product with range check after every beat.
  function automatic logic [63:0] model_acc(input int aw, input int lane, input int nb,
                                            input bit sgn, input bit sat, output bit ovf);
    longint s, p, lo, hi, av, bv, span;
    logic [IN_W-1:0] ab, bb;
    ovf = 1'b0;
    s = 0;
    span = longint'(1) << aw;
    if (sgn) begin lo = -(span / 2); hi = span / 2 - 1; end
    else     begin lo = 0;           hi = span - 1;     end
    for (int k = 0; k < nb; k++) begin
      ab = va[k][lane*IN_W +: IN_W];
      bb = vb[k][lane*IN_W +: IN_W];
      if (sgn) begin av = longint'($signed(ab)); bv = longint'($signed(bb)); end
      else     begin av = longint'(ab);          bv = longint'(bb);          end
      p = av * bv;
      s = (k == 0) ? p : s + p;
      if (s > hi) begin ovf = 1'b1; s = sat ? hi : s - span; end
      else if (s < lo) begin ovf = 1'b1; s = sat ? lo : s + span; end
    end
    return 64'(s & (span - 1));
  endfunction

  function automatic logic [IN_W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0: return 8'h80;
      1: return 8'h7F;
      2: return 8'hFF;
      default: return IN_W'($urandom);
    endcase
  endfunction

  task automatic fill_random(input int nb);
    for (int k = 0; k < nb; k++)
      for (int l = 0; l < LANES; l++) begin
        va[k][l*IN_W +: IN_W] = rnd_op();
        vb[k][l*IN_W +: IN_W] = rnd_op();
      end
  endtask

  task automatic cfg_write(input bit sgn, input bit sat, input int len);
    cfg_we = 1'b1; cfg_signed = sgn; cfg_sat = sat; cfg_len = LEN_W'(len);
    step();
    cfg_we = 1'b0;
    cur_sgn = sgn; cur_sat = sat;
  endtask

  task automatic send_beat(input int k);
    in_valid = 1'b1; in_a = va[k]; in_b = vb[k];
    step();
    in_valid = 1'b0;
  endtask

  // Called on the cycle after the last beat: checks result, holds, then handshakes.
  task automatic check_result(input int nb, input int hold);
    logic [63:0] e;
    bit eo;
    logic [LANES*24-1:0] s24;
    logic [LANES*16-1:0] s16;
    chk("out_valid24", 64'(out_valid24), 64'(1));
    chk("out_valid16", 64'(out_valid16), 64'(1));
    chk("in_ready_hold", 64'(in_ready24), 64'(0));
    for (int l = 0; l < LANES; l++) begin
      e = model_acc(24, l, nb, cur_sgn, cur_sat, eo);
      chk("acc24", 64'(out_acc24[l*24 +: 24]), e);
      chk("ovf24", 64'(out_ovf24[l]), 64'(eo));
      e = model_acc(16, l, nb, cur_sgn, cur_sat, eo);
      chk("acc16", 64'(out_acc16[l*16 +: 16]), e);
      chk("ovf16", 64'(out_ovf16[l]), 64'(eo));
    end
    s24 = out_acc24;
    s16 = out_acc16;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_a = $urandom; in_b = $urandom;
      step();
      chk("hold_valid", 64'(out_valid24), 64'(1));
      chk("hold_in_ready", 64'(in_ready16), 64'(0));
      chk("hold_stable", 64'((out_acc24 === s24) && (out_acc16 === s16)), 64'(1));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_valid", 64'(out_valid24 | out_valid16), 64'(0));
    chk("post_hs_in_ready", 64'(in_ready24 & in_ready16), 64'(1));
    chk("post_hs_busy", 64'(busy24 | busy16), 64'(0));
    chk("post_hs_retain", 64'((out_acc24 === s24) && (out_acc16 === s16)), 64'(1));
  endtask

  task automatic run_vec(input bit sgn, input bit sat, input int nb, input bit same,
                         input int hold, input bit gaps);
    if (!same) cfg_write(sgn, sat, nb - 1);
    cur_sgn = sgn; cur_sat = sat;
    for (int k = 0; k < nb; k++) begin
      if (gaps && $urandom_range(0, 2) == 0) step();
      in_valid = 1'b1; in_a = va[k]; in_b = vb[k];
      if (same && k == 0) begin
        cfg_we = 1'b1; cfg_signed = sgn; cfg_sat = sat; cfg_len = LEN_W'(nb - 1);
      end
      step();
      in_valid = 1'b0;
      cfg_we = 1'b0;
      chk("busy_mid", 64'(busy24), 64'(1));
    end
    check_result(nb, hold);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(in_ready24), 64'(1));
    chk("rst_out_valid", 64'(out_valid24), 64'(0));
    chk("rst_out_acc", 64'(out_acc24[63:0]), 64'(0));
    chk("rst_busy_err", 64'({busy24, error24, out_ovf24}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Signed 3-beat vector: lane0 3*4, lane1 -2*5
    for (int k = 0; k < 3; k++) begin
      va[k] = 32'h0000_FE03;
      vb[k] = 32'h0000_0504;
    end
    run_vec(1'b1, 1'b0, 3, 1'b0, 0, 1'b0);
    chk("t1_lane0", 64'(out_acc24[23:0]), 64'd36);
    chk("t1_lane1", 64'(out_acc24[47:24]), 64'hFFFFE2);

    // Same vector with backpressure, then a 1-beat vector must not carry residue
    run_vec(1'b1, 1'b0, 3, 1'b0, 5, 1'b0);
    va[0] = 32'h0000_0001;
    vb[0] = 32'h0000_0001;
    run_vec(1'b1, 1'b0, 1, 1'b0, 0, 1'b0);
    chk("t2_no_residue", 64'(out_acc24[23:0]), 64'd1);

    // -128*-128 twice: overflows 16-bit signed but not 24-bit
    va[0] = 32'h0000_0080; vb[0] = 32'h0000_0080;
    va[1] = 32'h0000_0080; vb[1] = 32'h0000_0080;
    run_vec(1'b1, 1'b1, 2, 1'b0, 1, 1'b0);
    chk("t3_sat16", 64'(out_acc16[15:0]), 64'h7FFF);
    chk("t3_sat24", 64'(out_acc24[23:0]), 64'h008000);
    run_vec(1'b1, 1'b0, 2, 1'b0, 0, 1'b0);
    chk("t3_wrap16", 64'(out_acc16[15:0]), 64'h8000);

    // Unsigned single beat on lane2, config applied in the same cycle as the beat
    va[0] = 32'h00FF_0000; vb[0] = 32'h00FF_0000;
    run_vec(1'b0, 1'b0, 1, 1'b1, 0, 1'b0);
    chk("t4_unsigned", 64'(out_acc24[71:48]), 64'h00FE01);
    run_vec(1'b1, 1'b0, 1, 1'b1, 0, 1'b0);
    chk("t4_signed", 64'(out_acc24[71:48]), 64'd1);

    // Config write during ACC is ignored and flags error
    fill_random(6);
    cfg_write(1'b1, 1'b0, 2);
    send_beat(0);
    cfg_we = 1'b1; cfg_len = LEN_W'(5); cfg_signed = 1'b0; cfg_sat = 1'b1;
    step();
    cfg_we = 1'b0;
    chk("t5_error_set", 64'({error24, error16}), 64'(3));
    send_beat(1);
    send_beat(2);
    check_result(3, 0);
    chk("t5_error_sticky", 64'(error24), 64'(1));
    cfg_write(1'b1, 1'b0, 5);
    chk("t5_error_clr", 64'({error24, error16}), 64'(0));
    for (int k = 0; k < 6; k++) begin
      send_beat(k);
      chk("t5_busy", 64'(busy24), 64'(1));
    end
    check_result(6, 2);

    // Reset mid-vector discards the partial vector and restores config defaults
    cfg_write(1'b0, 1'b1, 3);
    fill_random(2);
    send_beat(0);
    send_beat(1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(out_valid24), 64'(0));
    chk("t6_rst_ready", 64'(in_ready24), 64'(1));
    chk("t6_rst_busy", 64'(busy24 | busy16), 64'(0));
    chk("t6_rst_acc", 64'(out_acc24[63:0]), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    va[0] = 32'h0000_0007;
    vb[0] = 32'h0000_00FD;
    cur_sgn = 1'b1; cur_sat = 1'b0;
    send_beat(0);
    check_result(1, 0);
    chk("t6_minus21", 64'(out_acc24[23:0]), 64'hFFFFEB);

    // Randomised vectors
    for (int n = 0; n < 40; n++) begin
      int nb;
      nb = int'($urandom_range(1, 8));
      fill_random(nb);
      run_vec(1'($urandom), 1'($urandom), nb, 1'($urandom), int'($urandom_range(0, 3)), 1'b1);
    end
    chk("final_error", 64'({error24, error16}), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
